// File: rtl/fp_pkg.sv
// Shared constants for the linear-to-floating-point converter.
// Rounding-mode encodings travel with each sample through the pipeline.
package fp_pkg;

  localparam logic [1:0] RND_HALF_UP = 2'b00;
  localparam logic [1:0] RND_TRUNC   = 2'b01;
  localparam logic [1:0] RND_EVEN    = 2'b10;

endpackage

// File: rtl/fp_lead_extract.sv
// Combinational leading-one detect and significand/exponent extraction.
// Produces the round and sticky bits and clamps exponents that exceed EMAX.
module fp_lead_extract
  import fp_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4
) (
  input  logic [IN_W-1:0]  mag,
  output logic [EXP_W-1:0] e,
  output logic [MAN_W-1:0] f,
  output logic             r,
  output logic             st,
  output logic             sat
);

  localparam int PW   = $clog2(IN_W);
  localparam int EMAX = (1 << EXP_W) - 1;

  logic [PW-1:0]   p_s;
  logic [IN_W-1:0] norm_s;
  int              e_s;

  // leading-one position: the highest set bit overrides lower ones
  always_comb begin
    p_s = {PW{1'b0}};
    for (int i = 0; i < IN_W; i++) begin
      p_s = mag[i] ? PW'(i) : p_s;
    end
  end

  // shifting the leading one to the msb keeps every later slice constant-width
  assign norm_s = mag << (PW'(IN_W - 1) - p_s);
  assign e_s    = int'(p_s) - MAN_W + 1;

  // field extraction and pre-saturation
  always_comb begin
    e   = {EXP_W{1'b0}};
    f   = {MAN_W{1'b0}};
    r   = 1'b0;
    st  = 1'b0;
    sat = 1'b0;
    if (mag == {IN_W{1'b0}}) begin
      e = {EXP_W{1'b0}};
      f = {MAN_W{1'b0}};
    end else if (int'(p_s) < MAN_W) begin
      f = mag[MAN_W-1:0];
    end else if (e_s > EMAX) begin
      e   = {EXP_W{1'b1}};
      f   = {MAN_W{1'b1}};
      sat = 1'b1;
    end else begin
      e  = EXP_W'(e_s);
      f  = norm_s[IN_W-1 -: MAN_W];
      r  = norm_s[IN_W-1-MAN_W];
      st = |norm_s[IN_W-2-MAN_W:0];
    end
  end

endmodule

// File: rtl/fp_convert_pipe.sv
// Three-stage linear-to-floating-point converter with valid/ready flow control,
// per-sample rounding mode, saturation flag and saturating event counter.
module fp_convert_pipe
  import fp_pkg::*;
#(
  parameter int IN_W  = 12,
  parameter int EXP_W = 3,
  parameter int MAN_W = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_s,
  output logic [EXP_W-1:0] out_e,
  output logic [MAN_W-1:0] out_f,
  output logic             out_sat,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] sat_cnt
);

  localparam logic [EXP_W-1:0] EMAX   = {EXP_W{1'b1}};
  localparam logic [MAN_W-1:0] F_ONES = {MAN_W{1'b1}};
  localparam logic [MAN_W-1:0] F_MSB  = {1'b1, {(MAN_W-1){1'b0}}};

  logic             v1_r, v2_r;
  logic             s1_r, s2_r;
  logic [IN_W-1:0]  mag1_r;
  logic [1:0]       mode1_r, mode2_r;
  logic [EXP_W-1:0] e2_r;
  logic [MAN_W-1:0] f2_r;
  logic             r2_r, st2_r, sat2_r;

  logic             adv1_s, adv2_s, adv3_s;
  logic [IN_W-1:0]  mag_s;
  logic [EXP_W-1:0] ex_e_s;
  logic [MAN_W-1:0] ex_f_s;
  logic             ex_r_s, ex_st_s, ex_sat_s;
  logic             inc_s;
  logic [MAN_W:0]   sum_s;
  logic [EXP_W-1:0] rnd_e_s;
  logic [MAN_W-1:0] rnd_f_s;
  logic             rnd_sat_s;

  assign adv3_s   = !out_valid | out_ready;
  assign adv2_s   = !v2_r | adv3_s;
  assign adv1_s   = !v1_r | adv2_s;
  assign in_ready = adv1_s;

  // the most-negative input wraps to 100..0, which read unsigned is 2^(IN_W-1)
  assign mag_s = in_data[IN_W-1] ? (~in_data + {{(IN_W-1){1'b0}}, 1'b1}) : in_data;

  // stage 1: sign, magnitude and mode
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_r    <= 1'b0;
      s1_r    <= 1'b0;
      mag1_r  <= {IN_W{1'b0}};
      mode1_r <= 2'b00;
    end else if (adv1_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        s1_r    <= in_data[IN_W-1];
        mag1_r  <= mag_s;
        mode1_r <= in_mode;
      end
    end
  end

  fp_lead_extract #(
    .IN_W  (IN_W),
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_extract (
    .mag (mag1_r),
    .e   (ex_e_s),
    .f   (ex_f_s),
    .r   (ex_r_s),
    .st  (ex_st_s),
    .sat (ex_sat_s)
  );

  // stage 2: extracted fields awaiting rounding
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_r    <= 1'b0;
      s2_r    <= 1'b0;
      e2_r    <= {EXP_W{1'b0}};
      f2_r    <= {MAN_W{1'b0}};
      r2_r    <= 1'b0;
      st2_r   <= 1'b0;
      sat2_r  <= 1'b0;
      mode2_r <= 2'b00;
    end else if (adv2_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        s2_r    <= s1_r;
        e2_r    <= ex_e_s;
        f2_r    <= ex_f_s;
        r2_r    <= ex_r_s;
        st2_r   <= ex_st_s;
        sat2_r  <= ex_sat_s;
        mode2_r <= mode1_r;
      end
    end
  end

  // rounding increment and significand overflow handling
  always_comb begin
    inc_s = 1'b0;
    case (mode2_r)
      RND_HALF_UP: inc_s = r2_r;
      RND_TRUNC:   inc_s = 1'b0;
      RND_EVEN:    inc_s = r2_r & (st2_r | f2_r[0]);
      default:     inc_s = r2_r;
    endcase
    sum_s     = {1'b0, f2_r} + {{MAN_W{1'b0}}, inc_s};
    rnd_e_s   = e2_r;
    rnd_f_s   = sum_s[MAN_W-1:0];
    rnd_sat_s = 1'b0;
    if (sat2_r) begin
      rnd_e_s   = EMAX;
      rnd_f_s   = F_ONES;
      rnd_sat_s = 1'b1;
    end else if (sum_s[MAN_W] && (e2_r < EMAX)) begin
      rnd_e_s = e2_r + {{(EXP_W-1){1'b0}}, 1'b1};
      rnd_f_s = F_MSB;
    end else if (sum_s[MAN_W]) begin
      rnd_e_s   = EMAX;
      rnd_f_s   = F_ONES;
      rnd_sat_s = 1'b1;
    end else begin
      rnd_e_s   = e2_r;
      rnd_f_s   = sum_s[MAN_W-1:0];
      rnd_sat_s = 1'b0;
    end
  end

  // stage 3: registered outputs, held while the consumer stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_s     <= 1'b0;
      out_e     <= {EXP_W{1'b0}};
      out_f     <= {MAN_W{1'b0}};
      out_sat   <= 1'b0;
    end else if (adv3_s) begin
      out_valid <= v2_r;
      if (v2_r) begin
        out_s   <= s2_r;
        out_e   <= rnd_e_s;
        out_f   <= rnd_f_s;
        out_sat <= rnd_sat_s;
      end
    end
  end

  // saturated-result counter; clear wins over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sat_cnt <= {CNT_W{1'b0}};
    end else if (clr_cnt) begin
      sat_cnt <= {CNT_W{1'b0}};
    end else if (out_valid && out_ready && out_sat && (sat_cnt != {CNT_W{1'b1}})) begin
      sat_cnt <= sat_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_fp_convert_pipe.sv
// Directed bench for fp_convert_pipe: hand-computed conversions, saturation
// counter, back-pressure ordering and asynchronous reset behaviour.
module tb_fp_convert_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [11:0] in_data = 12'h000;
  logic [1:0]  in_mode = 2'b00;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_s;
  logic [2:0]  out_e;
  logic [3:0]  out_f;
  logic        out_sat;
  logic        clr_cnt = 1'b0;
  logic [7:0]  sat_cnt;

  int checks = 0;
  int failures = 0;

  fp_convert_pipe #(.IN_W(12), .EXP_W(3), .MAN_W(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_s     (out_s),
    .out_e     (out_e),
    .out_f     (out_f),
    .out_sat   (out_sat),
    .clr_cnt   (clr_cnt),
    .sat_cnt   (sat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one sample into an empty pipeline, result checked on the third cycle
  task automatic convert(input string tag, input logic [11:0] data, input logic [1:0] mode,
                         input logic es, input logic [2:0] ee, input logic [3:0] ef,
                         input logic esat);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = data;
    in_mode  = mode;
    #1 check_eq({tag, ".rdy"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 12'h000;
    check_eq({tag, ".lat1"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, ".lat2"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".s"}, 32'(out_s), 32'(es));
    check_eq({tag, ".e"}, 32'(out_e), 32'(ee));
    check_eq({tag, ".f"}, 32'(out_f), 32'(ef));
    check_eq({tag, ".sat"}, 32'(out_sat), 32'(esat));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [11:0] vals [5];
    int sent, got, first_cyc, last_cyc, seen;
    vals = '{12'd3, 12'd5, 12'd7, 12'd9, 12'd11};

    #1 rst = 1'b1;
    #2;
    check_eq("rst.valid", 32'(out_valid), 32'd0);
    check_eq("rst.f", 32'(out_f), 32'd0);
    check_eq("rst.cnt", 32'(sat_cnt), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    convert("zero",     12'h000, 2'b00, 1'b0, 3'd0, 4'h0, 1'b0);
    convert("v422",     12'h1A6, 2'b00, 1'b0, 3'd5, 4'hD, 1'b0);
    convert("v125.m0",  12'h07D, 2'b00, 1'b0, 3'd4, 4'h8, 1'b0);
    convert("v125.m1",  12'h07D, 2'b01, 1'b0, 3'd3, 4'hF, 1'b0);
    convert("v42.m0",   12'h02A, 2'b00, 1'b0, 3'd2, 4'hB, 1'b0);
    convert("v42.m2",   12'h02A, 2'b10, 1'b0, 3'd2, 4'hA, 1'b0);
    convert("v42.m1",   12'h02A, 2'b01, 1'b0, 3'd2, 4'hA, 1'b0);
    convert("v42.m3",   12'h02A, 2'b11, 1'b0, 3'd2, 4'hB, 1'b0);
    convert("v46.m2",   12'h02E, 2'b10, 1'b0, 3'd2, 4'hC, 1'b0);
    convert("v15",      12'h00F, 2'b00, 1'b0, 3'd0, 4'hF, 1'b0);
    convert("v16",      12'h010, 2'b00, 1'b0, 3'd1, 4'h8, 1'b0);
    convert("vneg422",  12'hE5A, 2'b00, 1'b1, 3'd5, 4'hD, 1'b0);
    convert("vmin",     12'h800, 2'b00, 1'b1, 3'd7, 4'hF, 1'b1);
    convert("vmax",     12'h7FF, 2'b00, 1'b0, 3'd7, 4'hF, 1'b1);
    @(negedge clk);
    check_eq("cnt.two", 32'(sat_cnt), 32'd2);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check_eq("cnt.clr", 32'(sat_cnt), 32'd0);

    // 300 back-to-back saturated samples
    in_valid = 1'b1;
    in_data  = 12'h800;
    in_mode  = 2'b00;
    sent = 0;
    for (int c = 0; c < 400 && sent < 300; c++) begin
      #1;
      if (in_ready) sent++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check_eq("stream.sent", 32'(sent), 32'd300);
    repeat (5) @(negedge clk);
    check_eq("cnt.hold", 32'(sat_cnt), 32'd255);

    // back-pressure: five samples, consumer stalled for the first eight cycles
    sent = 0;
    got = 0;
    first_cyc = 0;
    last_cyc = 0;
    for (int cyc = 0; cyc < 40 && got < 5; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 8);
      in_valid  = (sent < 5);
      in_data   = vals[(sent < 5) ? sent : 0];
      #1;
      if (cyc == 4 || cyc == 7) begin
        check_eq("stall.rdy", 32'(in_ready), 32'd0);
        check_eq("stall.valid", 32'(out_valid), 32'd1);
        check_eq("stall.f", 32'(out_f), 32'd3);
        check_eq("stall.sent", 32'(sent), 32'd3);
      end
      if (out_valid && out_ready) begin
        check_eq("order.f", 32'(out_f), 32'(vals[got]));
        check_eq("order.e", 32'(out_e), 32'd0);
        if (got == 0) first_cyc = cyc;
        last_cyc = cyc;
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0;
    check_eq("order.got", 32'(got), 32'd5);
    check_eq("order.sent", 32'(sent), 32'd5);
    check_eq("order.span", 32'(last_cyc - first_cyc), 32'd4);

    // asynchronous reset with two samples in flight
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 12'h1A6;
    in_mode   = 2'b00;
    @(negedge clk);
    in_data = 12'h07D;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check_eq("prerst.valid", 32'(out_valid), 32'd1);
    check_eq("prerst.f", 32'(out_f), 32'hD);
    #2 rst = 1'b1;
    #1;
    check_eq("arst.valid", 32'(out_valid), 32'd0);
    check_eq("arst.e", 32'(out_e), 32'd0);
    check_eq("arst.f", 32'(out_f), 32'd0);
    check_eq("arst.cnt", 32'(sat_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check_eq("arst.nothing", 32'(seen), 32'd0);
    convert("postrst", 12'h1A6, 2'b00, 1'b0, 3'd5, 4'hD, 1'b0);

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fp_convert_pipe.md
Name: fp_convert_pipe

Overview:
Pipelined, parametrised linear-to-floating-point converter. Accepts IN_W-bit two's-complement samples over a valid/ready handshake and emits sign, exponent and significand (value ≈ F·2^E) three cycles later, at one sample per cycle. Adds selectable rounding modes, an explicit saturation flag and a saturation event counter. Sits between the sample source and downstream FP consumers.

Parameters:
IN_W, 12, input width, two's complement; legal range 6 to 32.
EXP_W, 3, exponent width; EMAX = 2^EXP_W-1.
MAN_W, 4, significand width; legal range 2 to IN_W-2.
CNT_W, 8, saturation counter width.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  input sample valid
in_ready  out  1  converter can accept a sample this cycle
in_data  in  IN_W  two's-complement sample
in_mode  in  2  rounding mode; travels with its sample
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
out_s  out  1  sign
out_e  out  EXP_W  exponent
out_f  out  MAN_W  significand
out_sat  out  1  result was clamped
clr_cnt  in  1  synchronous clear of sat_cnt
sat_cnt  out  CNT_W  count of accepted saturated results

Behaviour:
- Reset, asynchronous: all stage valids 0. out_s, out_e, out_f, out_sat and sat_cnt are 0. Samples in flight are discarded.
- Stage 1: register the sample and mode. S = msb. mag = |in_data| in IN_W bits; the most-negative input gives mag = 2^(IN_W-1).
- Stage 2: p = index of the leading one of mag.
  - mag = 0: E=0, F=0.
  - p < MAN_W: E=0, F=mag[MAN_W-1:0], exact; round and sticky bits are 0.
  - Otherwise: E=p-MAN_W+1, F=mag[p -: MAN_W], round bit r=mag[p-MAN_W], sticky s = OR of the bits below r.
- Stage 2 pre-saturation: if E > EMAX, then E=EMAX, F=all ones, sat=1, and rounding is suppressed.
- Stage 3 rounding. inc is:
  - mode 00 (nearest, ties up) or 11 (reserved, same as 00): inc = r.
  - mode 01 (truncate): inc = 0.
  - mode 10 (nearest-even): inc = r & (s | F[0]).
- Stage 3 result:
  - F+inc overflows and E < EMAX: F = 1000…0, E = E+1.
  - F+inc overflows and E = EMAX: F = all ones, E = EMAX, sat=1.
- Handshake:
  - A stage loads when its valid is 0 or the next stage takes its data.
  - in_ready = !v1 | stage-1 advancing. in_ready depends combinationally on out_ready, which is permitted.
  - Transfers happen on in_valid&in_ready and on out_valid&out_ready.
  - Outputs are registered and held stable while out_valid & !out_ready.
  - Latency is 3 cycles from input transfer to out_valid. Throughput is 1/cycle. Order is preserved. Depth is 3 samples.
- sat_cnt:
  - Increments on each output transfer with out_sat=1 and holds at all ones.
  - clr_cnt has priority: clr_cnt together with an increment gives 0.

Decomposition:
- Shared package fp_pkg: round-mode constants RND_HALF_UP=2'b00, RND_TRUNC=2'b01, RND_EVEN=2'b10.
- One combinational sub-module, fp_lead_extract: leading-one detect plus F/E/r/s extraction and pre-saturation, parametrised on IN_W, EXP_W and MAN_W, instantiated in stage 2.
- Rounding and the handshake stay in the top level.

Test Plan:
- 12'h000 and 12'h1A6 (422), mode 00 → (0,0,0000), then (0,5,1101), sat=0. Both appear exactly 3 cycles after transfer.
- 12'h07D (125): mode 00 → E=4, F=1000. Mode 01 → E=3, F=1111.
- 12'h02A (42, a tie) → mode 00 gives E=2, F=1011. Modes 10 and 01 give E=2, F=1010. 12'h02E (46), mode 10 → E=2, F=1100.
- 12'h800 → S=1, E=7, F=1111, sat=1. 12'h7FF, mode 00 → S=0, E=7, F=1111, sat=1; sat_cnt=2 after both are accepted. Pulse clr_cnt → 0. 300 saturated results → sat_cnt holds 255.
- Stream 5 samples with out_ready=0 → in_ready drops after 3 accepted and out_valid holds the first result stable. Raise out_ready → all 5 emerge in order, one per cycle, with no drop or duplicate.
- Assert rst with 2 samples in flight → out_valid=0 and outputs zero immediately, without waiting for a clock edge; nothing emerges after release; the next sample converts normally.
